// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: exception codes and
// the stage occupancy encoding.
package pipe_pkg;

   // Exception codes carried alongside each entry; zero means no exception.
   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // Stage occupancy: nothing held, main entry only, main plus skid entry.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/pipe_exc_merge.sv
// Capture-side exception merge: picks the exception code for an incoming
// entry (upstream code wins over the locally detected one) and clears the
// masked control bits of any excepting entry so it cannot commit state.
module pipe_exc_merge
   import pipe_pkg::*;
#(
   parameter int                CTRL_W    = 64,
   parameter int                EXC_W     = 5,
   parameter logic [CTRL_W-1:0] KILL_MASK = '0
) (
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [EXC_W-1:0]  in_exc,
   input  logic [EXC_W-1:0]  local_exc,
   output logic [CTRL_W-1:0] cap_ctrl,
   output logic [EXC_W-1:0]  cap_exc
);

   // Priority select of the exception code, then kill of the masked controls.
   always_comb begin
      cap_exc  = (in_exc != '0) ? in_exc : local_exc;
      cap_ctrl = (cap_exc != '0) ? (in_ctrl & ~KILL_MASK) : in_ctrl;
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with exception capture and flush.
// Handshake: an entry moves across a port on a rising edge where valid and
// ready are both high; valid never depends on ready of the same port.
// Build option PIPE_SKID_EN: adds a skid entry so in_ready is a pure
// register output; without it the stage is a single entry whose in_ready
// is ~out_valid | out_ready.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = 160,
   parameter int                CTRL_W    = 64,
   parameter int                EXC_W     = 5,
   parameter logic [CTRL_W-1:0] KILL_MASK = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [EXC_W-1:0]  in_exc,
   input  logic [EXC_W-1:0]  local_exc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [EXC_W-1:0]  out_exc,
   output pipe_state_e       dbg_state
);

   logic [CTRL_W-1:0] cap_ctrl;
   logic [EXC_W-1:0]  cap_exc;

   pipe_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [EXC_W-1:0]  main_exc_q,  main_exc_d;
`ifdef PIPE_SKID_EN
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [EXC_W-1:0]  skid_exc_q,  skid_exc_d;
   logic              in_ready_q,  in_ready_d;
`endif

   logic in_xfer, out_xfer;
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // One merge unit serves both entries; the skid entry only ever stores
   // what would otherwise have been loaded into main.
   pipe_exc_merge #(
      .CTRL_W    (CTRL_W),
      .EXC_W     (EXC_W),
      .KILL_MASK (KILL_MASK)
   ) u_exc_merge (
      .in_ctrl   (in_ctrl),
      .in_exc    (in_exc),
      .local_exc (local_exc),
      .cap_ctrl  (cap_ctrl),
      .cap_exc   (cap_exc)
   );

   // State and entry registers; reset overrides flush and every transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         main_exc_q  <= '0;
`ifdef PIPE_SKID_EN
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_exc_q  <= '0;
         in_ready_q  <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         main_exc_q  <= main_exc_d;
`ifdef PIPE_SKID_EN
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_exc_q  <= skid_exc_d;
         in_ready_q  <= in_ready_d;
`endif
      end
   end

   // Next occupancy and entry contents; vacated entries are zeroed so that
   // bubbles leave the stage as all-zero without an output mux.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      main_exc_d  = main_exc_q;
`ifdef PIPE_SKID_EN
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_exc_d  = skid_exc_q;
`endif
      if (flush) begin
         state_d     = ST_EMPTY;
         main_data_d = '0;
         main_ctrl_d = '0;
         main_exc_d  = '0;
`ifdef PIPE_SKID_EN
         skid_data_d = '0;
         skid_ctrl_d = '0;
         skid_exc_d  = '0;
`endif
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_d     = ST_FULL;
                  main_data_d = in_data;
                  main_ctrl_d = cap_ctrl;
                  main_exc_d  = cap_exc;
               end
            end
            ST_FULL: begin
               if (in_xfer && out_xfer) begin
                  main_data_d = in_data;
                  main_ctrl_d = cap_ctrl;
                  main_exc_d  = cap_exc;
               end else if (out_xfer) begin
                  state_d     = ST_EMPTY;
                  main_data_d = '0;
                  main_ctrl_d = '0;
                  main_exc_d  = '0;
`ifdef PIPE_SKID_EN
               end else if (in_xfer) begin
                  state_d     = ST_SKID;
                  skid_data_d = in_data;
                  skid_ctrl_d = cap_ctrl;
                  skid_exc_d  = cap_exc;
`endif
               end
            end
`ifdef PIPE_SKID_EN
            ST_SKID: begin
               if (out_xfer) begin
                  state_d     = ST_FULL;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  main_exc_d  = skid_exc_q;
                  skid_data_d = '0;
                  skid_ctrl_d = '0;
                  skid_exc_d  = '0;
               end
            end
`endif
            default: state_d = ST_EMPTY;
         endcase
      end
`ifdef PIPE_SKID_EN
      in_ready_d = (state_d != ST_SKID);
`endif
   end

   // Outputs decoded from the registered state; only the single-entry
   // build lets out_ready reach in_ready.
   always_comb begin
      out_valid = (state_q != ST_EMPTY);
`ifdef PIPE_SKID_EN
      in_ready  = in_ready_q;
`else
      in_ready  = (state_q == ST_EMPTY) | out_ready;
`endif
      out_data  = main_data_q;
      out_ctrl  = main_ctrl_q;
      out_exc   = main_exc_q;
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vectors with literal expectations plus
// a FIFO-level reference model compared against the outputs every cycle.
// Works for both builds (PIPE_SKID_EN defined or not).
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam int DATA_W = 160;
   localparam int CTRL_W = 64;
   localparam int EXC_W  = 5;
   localparam logic [CTRL_W-1:0] KILL = 64'h1;
`ifdef PIPE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic [EXC_W-1:0]  in_exc = '0;
   logic [EXC_W-1:0]  local_exc = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [EXC_W-1:0]  out_exc;
   pipe_state_e       dut_state;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_stage_skid #(
      .DATA_W (DATA_W), .CTRL_W (CTRL_W), .EXC_W (EXC_W), .KILL_MASK (KILL)
   ) dut (
      .clk (clk), .reset (reset), .flush (flush),
      .in_valid (in_valid), .in_ready (in_ready),
      .in_data (in_data), .in_ctrl (in_ctrl), .in_exc (in_exc),
      .local_exc (local_exc),
      .out_valid (out_valid), .out_ready (out_ready),
      .out_data (out_data), .out_ctrl (out_ctrl), .out_exc (out_exc),
      .dbg_state (dut_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // The stage behaves as a FIFO of depth CAP; entries are stored as
   // captured (exception merged, controls killed).
   logic [DATA_W-1:0] exp_q[$];
   logic [CTRL_W-1:0] exp_c_q[$];
   logic [EXC_W-1:0]  exp_e_q[$];
   bit mdl_on = 1'b0;

   function automatic bit mdl_ready();
`ifdef PIPE_SKID_EN
      return exp_q.size() < CAP;
`else
      return (exp_q.size() == 0) || out_ready;
`endif
   endfunction

   always @(posedge clk) begin
      logic [EXC_W-1:0]  e;
      logic [CTRL_W-1:0] c;
      bit rdy;
      if (reset) begin
         exp_q.delete(); exp_c_q.delete(); exp_e_q.delete();
         mdl_on = 1'b1;
      end else if (mdl_on) begin
         if (flush) begin
            exp_q.delete(); exp_c_q.delete(); exp_e_q.delete();
         end else begin
            rdy = mdl_ready();
            if (exp_q.size() > 0 && out_ready) begin
               void'(exp_q.pop_front());
               void'(exp_c_q.pop_front());
               void'(exp_e_q.pop_front());
            end
            if (in_valid && rdy) begin
               e = (in_exc != 0) ? in_exc : local_exc;
               c = (e != 0) ? (in_ctrl & ~KILL) : in_ctrl;
               exp_q.push_back(in_data);
               exp_c_q.push_back(c);
               exp_e_q.push_back(e);
            end
         end
      end
   end

   // Compare process: every cycle after the first reset edge.
   always @(negedge clk) begin
      if (mdl_on) begin
         check("cyc_out_valid", out_valid, exp_q.size() > 0);
         check("cyc_in_ready", in_ready, mdl_ready());
         check("cyc_out_data", out_data, (exp_q.size() > 0) ? exp_q[0] : '0);
         check("cyc_out_ctrl", out_ctrl, (exp_q.size() > 0) ? exp_c_q[0] : '0);
         check("cyc_out_exc", out_exc, (exp_q.size() > 0) ? exp_e_q[0] : '0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input bit v, input logic [DATA_W-1:0] d,
                        input logic [CTRL_W-1:0] c, input logic [EXC_W-1:0] e,
                        input logic [EXC_W-1:0] le, input bit ordy, input bit fl);
      in_valid = v; in_data = d; in_ctrl = c; in_exc = e; local_exc = le;
      out_ready = ordy; flush = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check_bubble(input string name);
      check({name, "_valid"}, out_valid, 1'b0);
      check({name, "_data"}, out_data, '0);
      check({name, "_ctrl"}, out_ctrl, '0);
      check({name, "_exc"}, out_exc, '0);
      check({name, "_in_ready"}, in_ready, 1'b1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      // reset state
      tick(); tick();
      reset = 1'b0;
      check_bubble("reset");

      // streaming 1..8, one per cycle
      for (int i = 1; i <= 8; i++) begin
         drive(1, i, 64'h10, 0, 0, 1, 0);
         tick();
         check("stream_data", out_data, i);
         check("stream_in_ready", in_ready, 1'b1);
      end
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();
      check_bubble("stream_drain");

      // backpressure
      drive(1, 'hA, 0, 0, 0, 0, 0);
      tick();
      check("bp_first", out_data, 'hA);
      drive(1, 'hB, 0, 0, 0, 0, 0);
`ifdef PIPE_SKID_EN
      tick();
      check("bp_skid_state", dut_state, ST_SKID);
      check("bp_skid_in_ready", in_ready, 1'b0);
      check("bp_skid_hold", out_data, 'hA);
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();
      check("bp_second", out_data, 'hB);
      check("bp_in_ready_back", in_ready, 1'b1);
`else
      #1;
      check("bp_comb_in_ready", in_ready, 1'b0);
      tick();
      check("bp_hold", out_data, 'hA);
      drive(1, 'hB, 0, 0, 0, 1, 0);
      tick();
      check("bp_second", out_data, 'hB);
      drive(0, 0, 0, 0, 0, 1, 0);
`endif
      tick();
      check("bp_empty", out_valid, 1'b0);

      // exception capture and kill
      drive(1, 'h55, 64'h3, 0, EXC_ADEL, 1, 0);
      tick();
      check("exc_local_code", out_exc, 4);
      check("exc_local_ctrl", out_ctrl, 64'h2);
      check("exc_local_data", out_data, 'h55);
      drive(1, 'h56, 64'h3, EXC_OV, EXC_ADEL, 1, 0);
      tick();
      check("exc_up_code", out_exc, 12);
      check("exc_up_ctrl", out_ctrl, 64'h2);
      drive(1, 'h57, 64'h3, 0, 0, 1, 0);
      tick();
      check("exc_none_ctrl", out_ctrl, 64'h3);
      check("exc_none_code", out_exc, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();

      // flush with the stage full (and skid held in the skid build)
      drive(1, 'hA, 64'h1, 0, 0, 0, 0);
      tick();
      drive(1, 'hB, 64'h1, 0, 0, 0, 0);
      tick();
      drive(1, 'hC, 64'h1, 0, 0, 0, 1);
      tick();
      check_bubble("flush_full");
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();
      check("flush_no_ghost", out_valid, 1'b0);

      // flush drops a same-cycle input that would otherwise be accepted
      drive(1, 'hD, 0, 0, 0, 1, 0);
      tick();
      drive(1, 'hE, 0, 0, 0, 1, 1);
      tick();
      check_bubble("flush_drop");
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();
      check("flush_drop_gone", out_valid, 1'b0);

      // reset while full
      drive(1, 'hDEAD, 64'h7, 0, 0, 0, 0);
      tick();
      check("rst_full_data", out_data, 'hDEAD);
      drive(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_bubble("rst_mid");

      // reset together with flush behaves as reset
      drive(1, 'h77, 0, 0, 0, 0, 0);
      tick();
      drive(1, 'h78, 0, 0, 0, 0, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      check_bubble("rst_flush");

      // in_ready timing while full with the output stalled
      drive(1, 'h7, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
`ifdef PIPE_SKID_EN
      check("rdy_full_stall", in_ready, 1'b1);
`else
      check("rdy_full_stall", in_ready, 1'b0);
`endif
      out_ready = 1'b1;
      #1;
      check("rdy_full_go", in_ready, 1'b1);
      tick();
      check("rdy_drained", out_valid, 1'b0);

      // mixed traffic, checked by the cycle compare
      for (int i = 0; i < 40; i++) begin
         drive((i % 3) != 0, 'h100 + i, i, ((i % 7) == 0) ? EXC_RI : '0,
               ((i % 5) == 0) ? EXC_ADES : '0, (i % 4) != 1, i == 25);
         tick();
      end
      drive(0, 0, 0, 0, 0, 1, 0);
      tick(); tick(); tick();
      check("final_empty", out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
